disk_uart_responder: RTL and testbench

- UART-side sector server: the responder for the Disk controller's serial initiator.
- Accepts 8N1 command frames on rxd and serves sectors from an internal byte memory.
- Read commands stream a sector back on txd. Write commands store an incoming sector and return ACK.
- Replaces the host PC in self-contained simulation and on-board loopback tests.

---
 rtl/disk_uart_responder.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_disk_uart_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disk_uart_responder.sv
// disk_uart_responder
//   UART-side sector server. Receives 8N1 command frames on rxd and serves
//   sectors from an internal byte memory:
//     0x52 <s>            -> stream sector s back on txd
//     0x57 <s> <bytes..>  -> store SECTOR_BYTES bytes into sector s, reply 0x06
//     anything invalid    -> reply 0x15
//   An idle gap of TIMEOUT_CLKS between bytes of a frame aborts it silently.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rxd        serial in, idle high, asynchronous to clk
//   txd        serial out, idle high
//   busy       high whenever the command FSM is not idle
//   state      command FSM state code (IDLE=0 .. SEND_NAK=5)
//   frame_err  one-cycle pulse when a received stop bit samples 0
//   cmd_done   one-cycle pulse when a command's response has fully gone out
module disk_uart_responder #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SECTOR_BYTES = 512,
  parameter int NUM_SECTORS  = 4,
  parameter int TIMEOUT_CLKS = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       txd,
  output logic       busy,
  output logic [2:0] state,
  output logic       frame_err,
  output logic       cmd_done
);

  localparam int IW    = $clog2(SECTOR_BYTES);
  localparam int DEPTH = NUM_SECTORS * SECTOR_BYTES;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int TW    = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(SECTOR_BYTES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(TIMEOUT_CLKS - 1);

  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_SECT = 3'd1,
    S_RD_SEND  = 3'd2,
    S_WR_RECV  = 3'd3,
    S_SEND_ACK = 3'd4,
    S_SEND_NAK = 3'd5
  } st_t;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_ph_t;

  // ---------------------------------------------------------------- RX
  logic          rx_s1, rx_s2, rx_s3;   // s1/s2 synchroniser, s3 edge history
  rx_ph_t        rx_ph;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;                 // holds the received byte after stop
  logic          rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      rx_ph     <= R_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= rxd;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_ph)
        R_IDLE: begin
          // falling edge only: a stop bit stuck at 0 must not retrigger
          if (rx_s3 && !rx_s2) begin
            rx_ph  <= R_START;
            rx_cnt <= '0;
          end
        end
        R_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_ph  <= rx_s2 ? R_IDLE : R_DATA;   // high at mid-start: glitch
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_ph <= R_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_ph  <= R_IDLE;
            if (rx_s2) rx_valid  <= 1'b1;
            else       frame_err <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_ph <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM regs
  st_t           st;
  logic          op_wr;
  logic [7:0]    sect_q;
  logic [IW-1:0] idx;
  logic          sent_all;   // last byte of the response already launched
  logic [TW-1:0] gap;

  assign state = st;

  // sectors are a power of two in size, so {sector, index} is the address
  logic [AW-1:0] addr;
  assign addr = AW'({sect_q, idx});

  logic [7:0] mem [DEPTH];
  logic       mem_we;
  assign mem_we = (st == S_WR_RECV) && rx_valid;

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= rx_sh;
  end

  // ---------------------------------------------------------------- TX
  logic          tx_active;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bitn;    // 0 start, 1..8 data, 9 stop
  logic [8:0]    tx_sh;
  logic          tx_last, tx_ready, tx_req, tx_fire;
  logic [7:0]    tx_byte;

  // a new byte may load in the final cycle of the previous stop bit,
  // which gives back-to-back frames with no idle gap
  assign tx_last  = tx_active && (tx_cnt == BIT_END) && (tx_bitn == 4'd9);
  assign tx_ready = !tx_active || tx_last;
  assign tx_fire  = tx_req && tx_ready;

  always_comb begin
    tx_req  = 1'b0;
    tx_byte = mem[addr];
    case (st)
      S_RD_SEND:  tx_req = !sent_all;
      S_SEND_ACK: begin tx_req = !sent_all; tx_byte = ACK; end
      S_SEND_NAK: begin tx_req = !sent_all; tx_byte = NAK; end
      default:    tx_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_bitn   <= '0;
      tx_sh     <= '1;
      txd       <= 1'b1;
    end else if (tx_fire) begin
      tx_active <= 1'b1;
      tx_cnt    <= '0;
      tx_bitn   <= '0;
      tx_sh     <= {1'b1, tx_byte};
      txd       <= 1'b0;
    end else if (tx_active) begin
      if (tx_cnt == BIT_END) begin
        tx_cnt <= '0;
        if (tx_bitn == 4'd9) begin
          tx_active <= 1'b0;
          txd       <= 1'b1;
        end else begin
          txd     <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_bitn <= tx_bitn + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- command FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      busy     <= 1'b0;
      cmd_done <= 1'b0;
      op_wr    <= 1'b0;
      sect_q   <= '0;
      idx      <= '0;
      sent_all <= 1'b0;
      gap      <= '0;
    end else begin
      cmd_done <= 1'b0;
      case (st)
        S_IDLE: begin
          if (rx_valid) begin
            gap      <= '0;
            sent_all <= 1'b0;
            busy     <= 1'b1;
            if (rx_sh == OP_RD || rx_sh == OP_WR) begin
              op_wr <= (rx_sh == OP_WR);
              st    <= S_GET_SECT;
            end else begin
              st <= S_SEND_NAK;
            end
          end
        end
        S_GET_SECT: begin
          if (rx_valid) begin
            gap      <= '0;
            sent_all <= 1'b0;
            if ({24'd0, rx_sh} >= 32'(NUM_SECTORS)) begin
              st <= S_SEND_NAK;
            end else begin
              sect_q <= rx_sh;
              idx    <= '0;
              st     <= op_wr ? S_WR_RECV : S_RD_SEND;
            end
          end else if (gap == GAP_LAST) begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end else begin
            gap <= gap + TW'(1);
          end
        end
        S_RD_SEND: begin
          if (tx_fire) begin
            if (idx == IDX_LAST) sent_all <= 1'b1;
            else                 idx      <= idx + IW'(1);
          end
          if (sent_all && tx_last) begin
            cmd_done <= 1'b1;
            st       <= S_IDLE;
            busy     <= 1'b0;
          end
        end
        S_WR_RECV: begin
          // mem_we stores the byte at the current index this same cycle
          if (rx_valid) begin
            gap <= '0;
            if (idx == IDX_LAST) begin
              sent_all <= 1'b0;
              st       <= S_SEND_ACK;
            end else begin
              idx <= idx + IW'(1);
            end
          end else if (gap == GAP_LAST) begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end else begin
            gap <= gap + TW'(1);
          end
        end
        S_SEND_ACK, S_SEND_NAK: begin
          if (tx_fire) sent_all <= 1'b1;
          if (sent_all && tx_last) begin
            cmd_done <= 1'b1;
            st       <= S_IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          st   <= S_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disk_uart_responder.sv
// Bench for disk_uart_responder: drives UART command frames, decodes txd
// with an independent UART receiver, and compares responses against a
// table of fixed vectors, hand sequences and a sector-memory model.
module tb_disk_uart_responder;

  localparam int CPB = 4;
  localparam int SB  = 4;
  localparam int NS  = 4;
  localparam int TO  = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       txd, busy, frame_err, cmd_done;
  logic [2:0] state;

  disk_uart_responder #(
    .CLKS_PER_BIT(CPB), .SECTOR_BYTES(SB), .NUM_SECTORS(NS), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .txd(txd), .busy(busy),
    .state(state), .frame_err(frame_err), .cmd_done(cmd_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int n_ferr = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cmd_done)  n_done <= n_done + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
  end

  // UART decoder on txd: bytes and the cycle each start bit was seen
  logic [7:0] rq[$];
  int         tq[$];
  logic       txd_prev = 1'b1;

  initial begin
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (txd_prev === 1'b1 && txd === 1'b0) begin
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        rq.push_back(b);
        tq.push_back(t0);
      end
      txd_prev = txd;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  typedef struct packed {
    logic [0:5][7:0] cmd;
    int              ncmd;
    logic [0:3][7:0] rsp;
    int              nrsp;
  } vec_t;

  // sector memory model
  logic [7:0] mm [NS*SB];

  task automatic model_cmd(input logic [0:5][7:0] c, input int nc,
                           output logic [0:3][7:0] r, output int nr);
    int s;
    r  = '0;
    nr = 1;
    if (c[0] != 8'h52 && c[0] != 8'h57) r[0] = 8'h15;
    else if (nc < 2 || int'(c[1]) >= NS) r[0] = 8'h15;
    else begin
      s = int'(c[1]);
      if (c[0] == 8'h57) begin
        for (int i = 0; i < SB; i++) mm[s*SB+i] = c[2+i];
        r[0] = 8'h06;
      end else begin
        for (int i = 0; i < SB; i++) r[i] = mm[s*SB+i];
        nr = SB;
      end
    end
  endtask

  task automatic run_cmd(input string nm, input logic [0:5][7:0] c, input int nc,
                         input logic [0:3][7:0] r, input int nr);
    int d0, k;
    rq.delete();
    tq.delete();
    d0 = n_done;
    for (int i = 0; i < nc; i++) send_byte(c[i], 1'b1);
    k = 0;
    while (n_done == d0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk({nm, " cmd_done"}, n_done, d0 + 1);
    chk({nm, " rsp_len"}, rq.size(), nr);
    for (int i = 0; i < nr && i < rq.size(); i++)
      chk($sformatf("%s byte%0d", nm, i), rq[i], r[i]);
    for (int i = 1; i < nr && i < tq.size(); i++)
      chk($sformatf("%s gap%0d", nm, i), tq[i] - tq[i-1], 10 * CPB);
    chk({nm, " busy"}, busy, 1'b0);
    chk({nm, " state"}, state, 3'd0);
  endtask

  vec_t vt [10];

  initial begin
    logic [0:5][7:0] c;
    logic [0:3][7:0] r;
    int nc, nr, d0, f0, op;

    vt[0] = '{cmd: {8'h57, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40}, ncmd: 6, rsp: {8'h06, 24'h0}, nrsp: 1};
    vt[1] = '{cmd: {8'h57, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, ncmd: 6, rsp: {8'h06, 24'h0}, nrsp: 1};
    vt[2] = '{cmd: {8'h52, 8'h01, 32'h0},                    ncmd: 2, rsp: 32'hAABBCCDD,       nrsp: 4};
    vt[3] = '{cmd: {8'h57, 8'h02, 8'h21, 8'h22, 8'h23, 8'h24}, ncmd: 6, rsp: {8'h06, 24'h0}, nrsp: 1};
    vt[4] = '{cmd: {8'h57, 8'h03, 8'hF0, 8'hE1, 8'hD2, 8'hC3}, ncmd: 6, rsp: {8'h06, 24'h0}, nrsp: 1};
    vt[5] = '{cmd: {8'h41, 40'h0},                           ncmd: 1, rsp: {8'h15, 24'h0},    nrsp: 1};
    vt[6] = '{cmd: {8'h52, 8'h01, 32'h0},                    ncmd: 2, rsp: 32'hAABBCCDD,       nrsp: 4};
    vt[7] = '{cmd: {8'h52, 8'h04, 32'h0},                    ncmd: 2, rsp: {8'h15, 24'h0},    nrsp: 1};
    vt[8] = '{cmd: {8'h52, 8'h00, 32'h0},                    ncmd: 2, rsp: 32'h10203040,       nrsp: 4};
    vt[9] = '{cmd: {8'h57, 8'hFF, 32'h0},                    ncmd: 2, rsp: {8'h15, 24'h0},    nrsp: 1};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst txd", txd, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst state", state, 3'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post-rst frame_err", frame_err, 1'b0);
    chk("post-rst cmd_done", cmd_done, 1'b0);
    chk("post-rst txd", txd, 1'b1);

    // fixed vectors
    for (int v = 0; v < 10; v++) begin
      model_cmd(vt[v].cmd, vt[v].ncmd, r, nr);
      run_cmd($sformatf("vec%0d", v), vt[v].cmd, vt[v].ncmd, vt[v].rsp, vt[v].nrsp);
    end

    // timeout inside a write: one byte stored, no reply, no cmd_done
    rq.delete();
    d0 = n_done;
    send_byte(8'h57, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (50) @(negedge clk);
    chk("to mid state", state, 3'd3);
    repeat (250) @(negedge clk);
    chk("to state", state, 3'd0);
    chk("to busy", busy, 1'b0);
    chk("to no reply", rq.size(), 0);
    chk("to no done", n_done, d0);
    mm[2*SB] = 8'h11;
    run_cmd("to readback", {8'h52, 8'h02, 32'h0}, 2, 32'h11222324, 4);

    // framing error, then a one-clock glitch
    rq.delete();
    d0 = n_done;
    f0 = n_ferr;
    send_byte(8'h52, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr count", n_ferr, f0 + 1);
    chk("ferr state", state, 3'd0);
    @(negedge clk) rxd = 1'b0;
    @(negedge clk) rxd = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch state", state, 3'd0);
    chk("glitch no reply", rq.size(), 0);
    chk("glitch ferr", n_ferr, f0 + 1);
    chk("glitch no done", n_done, d0);

    // reset during the 2nd data byte of a read
    rq.delete();
    send_byte(8'h52, 1'b1);
    send_byte(8'h01, 1'b1);
    begin
      int k = 0;
      while (rq.size() < 1 && k < 2000) begin
        @(negedge clk);
        k++;
      end
      chk("rstx first byte seen", (k < 2000), 1'b1);
    end
    repeat (10) @(negedge clk);
    chk("rstx mid-byte state", state, 3'd2);
    rst_n = 1'b0;
    #1;
    chk("rstx txd", txd, 1'b1);
    chk("rstx state", state, 3'd0);
    chk("rstx busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    run_cmd("rstx reread", {8'h52, 8'h01, 32'h0}, 2, 32'hAABBCCDD, 4);

    // randomized commands against the memory model
    for (int n = 0; n < 24; n++) begin
      c  = '0;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        c[0] = 8'h52; c[1] = 8'($urandom_range(0, NS-1)); nc = 2;
      end else if (op <= 7) begin
        c[0] = 8'h57; c[1] = 8'($urandom_range(0, NS-1)); nc = 2 + SB;
        for (int i = 0; i < SB; i++) c[2+i] = 8'($urandom_range(0, 255));
      end else if (op == 8) begin
        do c[0] = 8'($urandom_range(0, 255)); while (c[0] == 8'h52 || c[0] == 8'h57);
        nc = 1;
      end else begin
        c[0] = ($urandom_range(0, 1) == 0) ? 8'h52 : 8'h57;
        c[1] = 8'($urandom_range(NS, 255)); nc = 2;
      end
      model_cmd(c, nc, r, nr);
      run_cmd($sformatf("rnd%0d", n), c, nc, r, nr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
